// File: rtl/rv32m_muldiv.sv
// rv32m_muldiv: iterative RV32M multiply/divide unit behind a start/done handshake.
// Define RV32M_FAST_MUL_EN to make multiplies single-cycle combinational; divides stay serial.
module rv32m_muldiv #(
  parameter int OP_W = 3,
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [OP_W-1:0] i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_y
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t          r_state;
  logic [4:0]      r_cnt;
  logic [OP_W-1:0] r_op;
  logic [63:0]     r_acc;
  logic [63:0]     r_mcand;
  logic [31:0]     r_mplier;
  logic            r_neg_q;
  logic            r_neg_r;
  logic        w_div, w_a_sg, w_b_sg, w_a_neg, w_b_neg, w_zero, w_ovf, w_fast, w_ge;
  logic [31:0] w_a_mag, w_b_mag, w_spec_y, w_fast_y, w_sub, w_q, w_r, w_calc_y;
  logic [32:0] w_sh;
  logic [63:0] w_acc_nxt;
  assign w_div    = i_op[2];
  assign w_a_sg   = w_div ? ~i_op[0] : (i_op[1] ^ i_op[0]);
  assign w_b_sg   = w_div ? ~i_op[0] : (i_op[1:0] == 2'd1);
  assign w_a_neg  = w_a_sg & i_a[31];
  assign w_b_neg  = w_b_sg & i_b[31];
  assign w_a_mag  = w_a_neg ? -i_a : i_a;
  assign w_b_mag  = w_b_neg ? -i_b : i_b;
  assign w_zero   = w_div && (i_b == 32'h0);
  assign w_ovf    = w_div && !i_op[0] && (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);
  assign w_spec_y = w_zero ? (i_op[1] ? i_a : 32'hFFFF_FFFF) : (i_op[1] ? 32'h0 : 32'h8000_0000);
`ifdef RV32M_FAST_MUL_EN
  logic [63:0] w_prod;
  // Sign-extended 64-bit product equals the 33x33 signed product modulo 2^64.
  assign w_prod   = {{32{w_a_neg}}, i_a} * {{32{w_b_neg}}, i_b};
  assign w_fast   = !w_div;
  assign w_fast_y = (i_op[1:0] == 2'd0) ? w_prod[31:0] : w_prod[63:32];
`else
  assign w_fast   = 1'b0;
  assign w_fast_y = 32'h0;
`endif
  // Divide keeps {remainder, quotient} in r_acc and the divisor magnitude in r_mcand[31:0].
  assign w_sh      = {r_acc[63:32], r_acc[31]};
  assign w_ge      = w_sh >= {1'b0, r_mcand[31:0]};
  assign w_sub     = w_sh[31:0] - r_mcand[31:0];
  assign w_acc_nxt = r_op[2] ? {w_ge ? w_sub : w_sh[31:0], r_acc[30:0], w_ge}
                             : r_acc + (r_mplier[0] ? r_mcand : 64'h0);
  assign w_q       = w_acc_nxt[31:0];
  assign w_r       = w_acc_nxt[63:32];
  assign w_calc_y  = r_op[2] ? (r_op[1] ? (r_neg_r ? -w_r : w_r) : (r_neg_q ? -w_q : w_q))
                             : ((r_op[1:0] == 2'd0) ? w_acc_nxt[31:0] : w_acc_nxt[63:32]);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= 5'd0;
      r_op     <= '0;
      r_acc    <= 64'h0;
      r_mcand  <= 64'h0;
      r_mplier <= 32'h0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_y      <= '0;
    end else if (i_flush) begin
      r_state <= IDLE;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_start) begin
          r_op     <= i_op;
          r_cnt    <= 5'd0;
          // A negative multiplier's bit-32 weight of -2^32 is preloaded as -(a << 32).
          r_acc    <= w_div ? {32'h0, w_a_mag} : (w_b_neg ? {-i_a, 32'h0} : 64'h0);
          r_mcand  <= w_div ? {32'h0, w_b_mag} : {{32{w_a_neg}}, i_a};
          r_mplier <= i_b;
          r_neg_q  <= w_a_neg ^ w_b_neg;
          r_neg_r  <= w_a_neg;
          o_busy   <= 1'b1;
          if (w_zero || w_ovf || w_fast) begin
            r_state <= DONE;
            o_done  <= 1'b1;
            o_y     <= (w_zero || w_ovf) ? w_spec_y : w_fast_y;
          end else
            r_state <= CALC;
        end
        CALC: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_op[2] ? r_mcand : {r_mcand[62:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[31:1]};
          r_cnt    <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_state <= DONE;
            o_done  <= 1'b1;
            o_y     <= w_calc_y;
          end
        end
        DONE: begin
          r_state <= IDLE;
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rv32m_muldiv.sv
// tb_rv32m_muldiv: directed checks of results, done latency, busy span, flush and reset abort.
module tb_rv32m_muldiv;
`ifdef RV32M_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  logic        clk, rst_n, start, flush, busy, done;
  logic [2:0]  op;
  logic [31:0] a, b, y;
  int checks = 0;
  int failures = 0;

  rv32m_muldiv dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op), .i_a(a), .i_b(b),
    .i_flush(flush), .o_busy(busy), .o_done(done), .o_y(y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] z);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = z;
    @(negedge clk);
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
  endtask

  // poke > 0 pulses a new start with other operands in cycle T+poke while busy.
  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x,
                     input logic [31:0] z, input logic [31:0] exp_y, input int exp_lat,
                     input int poke);
    int n;
    bit busy_ok;
    issue(o, x, z);
    n = 1;
    busy_ok = 1'b1;
    while (!done && n < 40) begin
      busy_ok &= busy;
      start = (n == poke);
      if (n == poke) begin a = 32'd200; b = 32'd3; end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    busy_ok &= busy;
    chk({tag, " latency"}, done ? n : -1, exp_lat);
    chk({tag, " result"}, y, exp_y);
    chk({tag, " busy span"}, {31'h0, busy_ok}, 32'h1);
    @(negedge clk);
    chk({tag, " idle after"}, {30'h0, busy, done}, 32'h0);
  endtask

  initial begin
    int n;
    bit seen;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; a = 32'h0; b = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset busy", {31'h0, busy}, 32'h0);
    chk("reset done", {31'h0, done}, 32'h0);
    chk("reset y", y, 32'h0);
    rst_n = 1'b1;

    run("MUL 7*-3",        3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, 0);
    run("MUL -1*-1",       3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, MUL_LAT, 0);
    run("MULH -1*-1",      3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT, 0);
    run("MULH min*min",    3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, 0);
    run("MULHU min*min",   3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, 0);
    run("MULHSU -1*max",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 0);
    run("MULHU max*max",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, 0);
    run("DIV -7/2",        3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33, 0);
    run("REM -7/2",        3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33, 0);
    run("DIVU 100/7",      3'd5, 32'd100,      32'd7,        32'd14,        33, 0);
    run("REMU 100/7",      3'd7, 32'd100,      32'd7,        32'd2,         33, 0);
    run("DIVU 5/0",        3'd5, 32'd5,        32'd0,        32'hFFFF_FFFF, 1,  0);
    run("REM 5/0",         3'd6, 32'd5,        32'd0,        32'd5,         1,  0);
    run("DIV ovf",         3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  0);
    run("REM ovf",         3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1,  0);
    run("DIVU busy start", 3'd5, 32'd100,      32'd7,        32'd14,        33, 5);

    issue(3'd5, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy", {31'h0, busy}, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen |= done;
      @(negedge clk);
    end
    chk("flush no done", {31'h0, seen}, 32'h0);
    chk("flush y held", y, 32'd14);

    issue(3'd4, 32'hFFFF_FFF9, 32'd2);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset busy", {31'h0, busy}, 32'h0);
    chk("midreset done", {31'h0, done}, 32'h0);
    chk("midreset y", y, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run("DIVU after reset", 3'd5, 32'd100, 32'd7, 32'd14, 33, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
